// File: rtl/univ_fifo_pkg.sv
// ----------------------------------------------------------------------------
// univ_fifo_pkg
// Shared definitions for the univ_async_fifo support logic.
//   arb_state_e  : write-port arbiter state encoding (idle / burst)
//   STAT_W       : width of the optional saturating statistics counters
//   owner_width  : index width for a requester count (never below 1 bit)
// ----------------------------------------------------------------------------
package univ_fifo_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  localparam int STAT_W = 16;

  function automatic int owner_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/univ_fifo_wr_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Returns the first set request bit found
// searching upward from rr_ptr, wrapping modulo NUM_REQ.
// Ports:
//   req     in  NUM_REQ  request vector
//   rr_ptr  in  IDX_W    search start index (must be < NUM_REQ)
//   sel     out IDX_W    selected index (0 when nothing requested)
//   any_req out 1        at least one request bit set
// ----------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   sel,
  output logic               any_req
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IDX_W:0]       idx_sum;

  // Rotate so that bit 0 of req_rot is requester rr_ptr; the doubled copy
  // supplies the wrapped-around bits.
  assign req_dbl = {req, req} >> rr_ptr;
  assign req_rot = req_dbl[NUM_REQ-1:0];

  // Scan from the far end so the closest request to rr_ptr is the last write.
  always_comb begin
    sel     = '0;
    any_req = 1'b0;
    idx_sum = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        idx_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
        if (idx_sum >= (IDX_W+1)'(NUM_REQ)) begin
          idx_sum = idx_sum - (IDX_W+1)'(NUM_REQ);
        end
        sel     = idx_sum[IDX_W-1:0];
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/univ_fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// univ_fifo_wr_arbiter
// Shares the single write port of univ_async_fifo among NUM_REQ requesters in
// the FIFO write-clock domain. Round-robin grant, each grant owns the port for
// at most MAX_BURST accepted words; the FIFO full flag stalls the owner.
//
// Ports:
//   wclk        in   write clock, rising edge
//   wrst        in   synchronous reset, active high
//   req         in   per-requester request level, held while data is valid
//   req_data    in   packed data, slice i belongs to requester i
//   gnt         out  registered one-hot grant
//   ack         out  combinational: owner's word accepted this cycle
//   fifo_full   in   FIFO full flag
//   fifo_w_en   out  FIFO write enable
//   fifo_data   out  FIFO data_in
//   busy        out  registered, high while in BURST
//   owner       out  registered index of current or last owner
//   stat_words  out  (UNIV_FIFO_ARB_STATS_EN) per-requester accepted words
//   stat_stall  out  (UNIV_FIFO_ARB_STATS_EN) BURST cycles stalled by full
//
// Optional feature macro: UNIV_FIFO_ARB_STATS_EN
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ARB_IDLE  | no owner; pick next requester round-robin from rr_ptr
// ARB_BURST | owner drives the FIFO write port until MAX_BURST words or
//           | it drops req; fifo_full holds the burst without a timeout
// ----------------------------------------------------------------------------
module univ_fifo_wr_arbiter
  import univ_fifo_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    owner
`ifdef UNIV_FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]     stat_words,
  output logic [STAT_W-1:0]             stat_stall
`endif
);

  localparam int OW = owner_width(NUM_REQ);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  arb_state_e           state;
  logic [OW-1:0]        rr_ptr;
  logic [BW-1:0]        burst_cnt;
  logic [OW-1:0]        sel;
  logic                 any_req;
  logic                 in_burst;
  logic                 owner_req;
  logic                 accept;
  logic                 last_word;
  logic                 burst_end;
  logic [OW-1:0]        owner_next;
  logic [DATA_WIDTH-1:0] slot [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    assign slot[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (OW)
  ) u_rr_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .sel     (sel),
    .any_req (any_req)
  );

  assign in_burst  = (state == ARB_BURST);
  assign owner_req = req[owner];

  // The reset cycle never writes, so a word in flight when wrst rises is
  // dropped rather than half-committed.
  assign accept    = in_burst && owner_req && !fifo_full && !wrst;
  assign last_word = (burst_cnt == BW'(MAX_BURST - 1));
  assign burst_end = in_burst && (!owner_req || (accept && last_word));

  assign owner_next = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + OW'(1);

  assign fifo_w_en = accept;
  assign fifo_data = in_burst ? slot[owner] : '0;
  assign ack       = accept ? (ONE_HOT0 << owner) : '0;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state     <= ARB_IDLE;
      gnt       <= '0;
      busy      <= 1'b0;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else if (state == ARB_IDLE) begin
      if (any_req) begin
        state     <= ARB_BURST;
        gnt       <= ONE_HOT0 << sel;
        owner     <= sel;
        busy      <= 1'b1;
        burst_cnt <= '0;
      end
    end else begin
      if (accept) begin
        burst_cnt <= burst_cnt + BW'(1);
      end
      // Returning to IDLE on every end forces one idle cycle between bursts.
      if (burst_end) begin
        state     <= ARB_IDLE;
        gnt       <= '0;
        busy      <= 1'b0;
        rr_ptr    <= owner_next;
        burst_cnt <= '0;
      end
    end
  end

`ifdef UNIV_FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] words_q [NUM_REQ];
  logic [STAT_W-1:0] stall_q;
  logic              stall_cyc;

  assign stall_cyc = in_burst && owner_req && fifo_full;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        words_q[i] <= '0;
      end
      stall_q <= '0;
    end else begin
      if (accept && (words_q[owner] != '1)) begin
        words_q[owner] <= words_q[owner] + STAT_W'(1);
      end
      if (stall_cyc && (stall_q != '1)) begin
        stall_q <= stall_q + STAT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_words[g*STAT_W +: STAT_W] = words_q[g];
  end
  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_univ_fifo_wr_arbiter.sv
module tb_univ_fifo_wr_arbiter;

  localparam int NR    = 4;
  localparam int DW    = 32;
  localparam int MB    = 4;
  localparam int OW    = 2;
  localparam int OBS_W = NR + 1 + OW + 1 + NR + DW;

  logic              wclk = 1'b0;
  logic              wrst = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic              fifo_full = 1'b0;
  logic [NR-1:0]     gnt;
  logic [NR-1:0]     ack;
  logic              fifo_w_en;
  logic [DW-1:0]     fifo_data;
  logic              busy;
  logic [OW-1:0]     owner;
`ifdef UNIV_FIFO_ARB_STATS_EN
  logic [NR*16-1:0]  stat_words;
  logic [15:0]       stat_stall;
  logic [NR*16+15:0] o_stats;
  logic [NR*16+15:0] e_stats;
`endif

  univ_fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .wclk       (wclk),
    .wrst       (wrst),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .ack        (ack),
    .fifo_full  (fifo_full),
    .fifo_w_en  (fifo_w_en),
    .fifo_data  (fifo_data),
    .busy       (busy),
    .owner      (owner)
`ifdef UNIV_FIFO_ARB_STATS_EN
    ,
    .stat_words (stat_words),
    .stat_stall (stat_stall)
`endif
  );

  always #5 wclk = ~wclk;

  int errors = 0;
  int checks = 0;

  // Requester-side bookkeeping: next word index per requester, FIFO contents.
  int word_idx [NR];
  int written [$];

  // Reference model: who owns the port, how many words it has had, where the
  // next round-robin search begins, and the statistics it implies.
  bit m_busy = 1'b0;
  int m_owner = 0;
  int m_ptr = 0;
  int m_cnt = 0;
  int m_words [NR];
  int m_stall = 0;

  logic [OBS_W-1:0] obs;
  logic [OBS_W-1:0] expv;
  logic [NR-1:0]    o_gnt;
  logic [NR-1:0]    o_ack;
  logic             o_busy;
  logic             o_wen;
  int               o_owner;

  task automatic drive(input logic [NR-1:0] r, input logic full, input logic rst);
    logic [NR-1:0] e_gnt;
    logic [NR-1:0] e_ack;
    logic          e_acc;
    logic [DW-1:0] e_data;
    bit            found;
    @(negedge wclk);
    req       = r;
    fifo_full = full;
    wrst      = rst;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = DW'(i*100 + word_idx[i]);
    #1;
    o_gnt   = gnt;
    o_ack   = ack;
    o_busy  = busy;
    o_wen   = fifo_w_en;
    o_owner = int'(owner);
    obs     = {gnt, busy, owner, fifo_w_en, ack, fifo_data};
    e_acc   = m_busy && r[m_owner] && !full && !rst;
    e_gnt   = '0;
    e_ack   = '0;
    e_data  = '0;
    if (m_busy) begin
      e_gnt[m_owner] = 1'b1;
      e_data = req_data[m_owner*DW +: DW];
    end
    if (e_acc) e_ack[m_owner] = 1'b1;
    expv = {e_gnt, m_busy, OW'(m_owner), e_acc, e_ack, e_data};
`ifdef UNIV_FIFO_ARB_STATS_EN
    o_stats = {stat_words, stat_stall};
    e_stats[15:0] = 16'(m_stall);
    for (int i = 0; i < NR; i++) e_stats[16+i*16 +: 16] = 16'(m_words[i]);
`endif
    if (fifo_w_en) written.push_back(int'(fifo_data));
    for (int i = 0; i < NR; i++) if (ack[i]) word_idx[i]++;
    if (rst) begin
      m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_stall = 0;
      for (int i = 0; i < NR; i++) m_words[i] = 0;
    end else begin
      if (e_acc && m_words[m_owner] < 65535) m_words[m_owner]++;
      if (m_busy && r[m_owner] && full && m_stall < 65535) m_stall++;
      if (!m_busy) begin
        if (r != '0) begin
          found = 1'b0;
          for (int k = 0; k < NR; k++) begin
            if (!found && r[(m_ptr + k) % NR]) begin
              m_owner = (m_ptr + k) % NR;
              found = 1'b1;
            end
          end
          m_busy = 1'b1;
          m_cnt  = 0;
        end
      end else begin
        if (e_acc) m_cnt++;
        if ((e_acc && m_cnt == MB) || !r[m_owner]) begin
          m_busy = 1'b0;
          m_ptr  = (m_owner + 1) % NR;
        end
      end
    end
  endtask

  task automatic reset_dut();
    drive('0, 1'b0, 1'b1);
    drive('0, 1'b0, 1'b1);
    for (int i = 0; i < NR; i++) word_idx[i] = 0;
    written.delete();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(4'b1111, 1'b0, 1'b1);
      checks++;
      if (o_gnt !== 4'b0000 || o_busy !== 1'b0 || o_wen !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got gnt=%b busy=%b wen=%b exp 0000/0/0", c, o_gnt, o_busy, o_wen);
      end
    end
    drive(4'b1111, 1'b0, 1'b0);
    checks++;
    if (obs !== expv || o_gnt !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release got gnt=%b exp 0000", o_gnt);
    end
    drive(4'b1111, 1'b0, 1'b0);
    checks++;
    if (obs !== expv || o_gnt !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_gnt got gnt=%b exp 0001", o_gnt);
    end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] r;
    logic [NR-1:0] prev_g = '0;
    int order [$];
    int zero_run = 0;
    int cyc = 0;
    bit done = 1'b0;
    int exp_w;
    reset_dut();
    while (!done && cyc < 200) begin
      for (int i = 0; i < NR; i++) r[i] = (word_idx[i] < 8);
      drive(r, 1'b0, 1'b0);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL rr_cycle cyc=%0d got=%h exp=%h", cyc, obs, expv);
      end
      if (o_gnt != '0 && prev_g == '0) begin
        order.push_back(o_owner);
        if (order.size() > 1) begin
          checks++;
          if (zero_run != 1) begin
            errors++;
            $display("FAIL rr_idle_gap got=%0d idle cycles exp 1", zero_run);
          end
        end
        zero_run = 0;
      end
      if (o_gnt == '0) zero_run++;
      prev_g = o_gnt;
      done = (word_idx[0] == 8 && word_idx[1] == 8 && word_idx[2] == 8 &&
              word_idx[3] == 8 && !o_busy);
      cyc++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL rr_timeout got done=0 exp done within 200 cycles");
    end
    checks++;
    if (order.size() != 8) begin
      errors++;
      $display("FAIL rr_grant_count got=%0d exp 8", order.size());
    end
    for (int g = 0; g < order.size() && g < 8; g++) begin
      checks++;
      if (order[g] != g % NR) begin
        errors++;
        $display("FAIL rr_order idx=%0d got=%0d exp=%0d", g, order[g], g % NR);
      end
    end
    checks++;
    if (written.size() != 32) begin
      errors++;
      $display("FAIL rr_words got=%0d exp 32", written.size());
    end
    for (int j = 0; j < written.size() && j < 32; j++) begin
      exp_w = ((j / 4) % NR) * 100 + ((j / 4) / NR) * 4 + (j % 4);
      checks++;
      if (written[j] != exp_w) begin
        errors++;
        $display("FAIL rr_fifo_data idx=%0d got=%0d exp=%0d", j, written[j], exp_w);
      end
    end
  endtask

  task automatic test_short_burst();
    int pulses = 0;
    reset_dut();
    for (int c = 0; c < 6; c++) begin
      drive({1'b0, (word_idx[2] < 2), 2'b00}, 1'b0, 1'b0);
      if (o_wen) pulses++;
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL short_cycle cyc=%0d got=%h exp=%h", c, obs, expv);
      end
    end
    checks++;
    if (pulses != 2 || written.size() != 2) begin
      errors++;
      $display("FAIL short_pulses got=%0d/%0d exp 2", pulses, written.size());
    end else begin
      checks++;
      if (written[0] != 200 || written[1] != 201) begin
        errors++;
        $display("FAIL short_data got=%0d,%0d exp 200,201", written[0], written[1]);
      end
    end
    drive(4'b1111, 1'b0, 1'b0);
    drive(4'b1111, 1'b0, 1'b0);
    checks++;
    if (o_gnt !== 4'b1000) begin
      errors++;
      $display("FAIL short_next_ptr got gnt=%b exp 1000", o_gnt);
    end
  endtask

  task automatic test_backpressure();
    int stall_n = 0;
    int words = 0;
    bit seen = 1'b0;
    bit ended = 1'b0;
    logic full;
    reset_dut();
    for (int c = 0; c < 60 && !ended; c++) begin
      full = (word_idx[1] >= 1 && stall_n < 5);
      if (full) stall_n++;
      drive(4'b0010, full, 1'b0);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL bp_cycle cyc=%0d got=%h exp=%h", c, obs, expv);
      end
      if (full) begin
        checks++;
        if (o_wen !== 1'b0 || o_ack !== '0) begin
          errors++;
          $display("FAIL bp_stall_write got wen=%b ack=%b exp 0/0000", o_wen, o_ack);
        end
      end
      if (o_gnt != '0) seen = 1'b1;
      if (seen && o_wen) words++;
      if (seen && o_gnt == '0) ended = 1'b1;
    end
    checks++;
    if (!ended || words != 4) begin
      errors++;
      $display("FAIL bp_burst_len got ended=%0d words=%0d exp 1/4", ended, words);
    end
    for (int j = 0; j < written.size() && j < 4; j++) begin
      checks++;
      if (written[j] != 100 + j) begin
        errors++;
        $display("FAIL bp_data idx=%0d got=%0d exp=%0d", j, written[j], 100 + j);
      end
    end
`ifdef UNIV_FIFO_ARB_STATS_EN
    checks++;
    if (stat_stall !== 16'd5) begin
      errors++;
      $display("FAIL bp_stat_stall got=%0d exp 5", stat_stall);
    end
`endif
  endtask

  task automatic test_wrap();
    logic [NR-1:0] prev_g = '0;
    int order [$];
    int exp_order [5] = '{2, 3, 0, 3, 0};
    reset_dut();
    for (int c = 0; c < 100 && order.size() < 5; c++) begin
      drive((word_idx[2] < 1) ? 4'b0100 : 4'b1001, 1'b0, 1'b0);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL wrap_cycle cyc=%0d got=%h exp=%h", c, obs, expv);
      end
      if (o_gnt != '0 && prev_g == '0) order.push_back(o_owner);
      prev_g = o_gnt;
    end
    checks++;
    if (order.size() != 5) begin
      errors++;
      $display("FAIL wrap_timeout got=%0d grants exp 5", order.size());
    end
    for (int g = 0; g < order.size(); g++) begin
      checks++;
      if (order[g] != exp_order[g]) begin
        errors++;
        $display("FAIL wrap_order idx=%0d got=%0d exp=%0d", g, order[g], exp_order[g]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int c = 0;
    reset_dut();
    while (word_idx[1] < 2 && c < 40) begin
      drive(4'b0110, 1'b0, 1'b0);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL mrst_cycle cyc=%0d got=%h exp=%h", c, obs, expv);
      end
      c++;
    end
    checks++;
    if (word_idx[1] != 2) begin
      errors++;
      $display("FAIL mrst_timeout got=%0d words exp 2", word_idx[1]);
    end
    drive(4'b0110, 1'b0, 1'b1);
    checks++;
    if (o_wen !== 1'b0 || o_ack !== '0) begin
      errors++;
      $display("FAIL mrst_no_write got wen=%b ack=%b exp 0/0000", o_wen, o_ack);
    end
    drive(4'b1111, 1'b0, 1'b0);
    checks++;
    if (o_gnt !== 4'b0000 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL mrst_gnt_clear got gnt=%b busy=%b exp 0000/0", o_gnt, o_busy);
    end
    drive(4'b1111, 1'b0, 1'b0);
    checks++;
    if (o_gnt !== 4'b0001) begin
      errors++;
      $display("FAIL mrst_rearb got gnt=%b exp 0001", o_gnt);
    end
  endtask

  task automatic test_random();
    logic [NR-1:0] r;
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) r[i] = ($urandom_range(0, 9) < 7);
      drive(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 63) == 0));
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL rand_cycle cyc=%0d got=%h exp=%h", c, obs, expv);
      end
      checks++;
      if (o_wen && fifo_full) begin
        errors++;
        $display("FAIL rand_full_write got wen=1 full=1 exp wen=0");
      end
`ifdef UNIV_FIFO_ARB_STATS_EN
      checks++;
      if (o_stats !== e_stats) begin
        errors++;
        $display("FAIL rand_stats cyc=%0d got=%h exp=%h", c, o_stats, e_stats);
      end
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      word_idx[i] = 0;
      m_words[i]  = 0;
    end
    @(posedge wclk);
    test_reset();
    test_round_robin();
    test_short_burst();
    test_backpressure();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/univ_fifo_wr_arbiter.md
Name: univ_fifo_wr_arbiter

Overview:
- Shares the single write port of univ_async_fifo among NUM_REQ write-domain requesters.
- Round-robin arbitration with bounded bursts: the granted requester owns the port for up to MAX_BURST accepted words.
- Drives FIFO w_en/data_in and honours the FIFO full flag.
- Sits entirely in the FIFO write-clock domain; the read side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 32, word width; matches the FIFO DATA_WIDTH.
- MAX_BURST, 4, maximum words accepted per grant (1..256).

Ports:
- wclk  in  1  write clock; all logic is on the rising edge.
- wrst  in  1  synchronous reset, active-high.
- req  in  NUM_REQ  per-requester write request; level, held while data is valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; slice i belongs to requester i.
- gnt  out  NUM_REQ  registered one-hot grant.
- ack  out  NUM_REQ  combinational; word from requester i accepted this cycle.
- fifo_full  in  1  FIFO full flag (write domain).
- fifo_w_en  out  1  FIFO write enable.
- fifo_data  out  DATA_WIDTH  FIFO data_in.
- busy  out  1  registered; high while in BURST.
- owner  out  $clog2(NUM_REQ)  registered index of the current or last owner.

Behaviour:
- Reset values: state=IDLE, gnt=0, busy=0, owner=0, rr_ptr=0, burst_cnt=0.
- ack, fifo_w_en and fifo_data are combinationally 0 while in IDLE.

IDLE:
- If any req bit is set, select the first set bit searching from rr_ptr upward, with modulo NUM_REQ wrap.
- Next cycle: state=BURST, gnt=onehot(sel), owner=sel, busy=1, burst_cnt=0.
- Grant latency is 1 cycle from req sampled high.

BURST:
- accept = req[owner] && !fifo_full.
- fifo_w_en = accept; fifo_data = req_data slice for owner (muxed even when not accepting); ack[owner] = accept.
- On each accept, burst_cnt increments.
- End of burst occurs when either:
  - an accept occurs with burst_cnt==MAX_BURST-1, or
  - req[owner]==0 (no write that cycle).
- On end of burst, next cycle: state=IDLE, gnt=0, busy=0, rr_ptr=owner+1 mod NUM_REQ.
- This forces exactly one idle cycle between bursts.

Boundary conditions:
- fifo_full high during BURST: no write, burst_cnt holds, grant is kept. No timeout.
- A requester may not drop req mid-word. Dropping req ends its burst; words not acked were never written.
- A non-owner req during a burst is ignored until the next IDLE arbitration.
- Single requester continuously active: bursts of MAX_BURST separated by 1 idle cycle.
- Wrap-around: rr_ptr at NUM_REQ-1 wraps to 0.
- wrst mid-burst: return to reset state on the next edge; the in-flight word that cycle is not written.
- fifo_w_en is never high while fifo_full is high (guaranteed by construction).

Optional Feature:
- Macro: UNIV_FIFO_ARB_STATS_EN.
- With it:
  - Adds output port stat_words, NUM_REQ*16 bits: per-requester saturating count of accepted words.
  - Adds output port stat_stall, 16 bits: saturating count of BURST cycles with req[owner]&&fifo_full.
  - Both counters clear on wrst.
- Without it: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package univ_fifo_pkg:
  - state encoding (ARB_IDLE=1'b0, ARB_BURST=1'b1)
  - localparam for owner width
  - stats counter width (16)
- Sub-module rr_pick:
  - combinational, parameterised NUM_REQ.
  - inputs: req, rr_ptr.
  - outputs: sel index, any_req.
  - Reusable by a future read-side scheduler.

Test Plan:
- Reset: assert wrst for 2 cycles with req=4'b1111 → gnt=0, busy=0, fifo_w_en=0 throughout; first gnt=4'b0001 one cycle after release.
- Round-robin: all 4 requesters hold req, each supplying 8 words (requester i sends i*100+k) → grant order 0,1,2,3,0,1,2,3; 4 writes per grant; 1 idle cycle between bursts; FIFO readout order matches.
- Short burst: req[2] only, dropped after 2 accepted words (200, 201) → exactly 2 fifo_w_en pulses, then IDLE; next arbitration starts at rr_ptr=3.
- Full backpressure: fifo_full forced high for 5 cycles mid-burst after word 1 → no fifo_w_en or ack during the stall; burst_cnt holds; burst resumes and completes at 4 words; stat_stall=5 when the macro is enabled.
- Wrap: only req[3] and req[0] active → grants alternate 3,0,3,0; after owner 3, rr_ptr=0.
- Mid-burst reset: wrst for 1 cycle after word 2 of a burst → no write on the reset cycle, gnt=0 next cycle, and re-arbitration starts from requester 0.
